// File: rtl/param_gemm_cim.sv
// Parametrised compute-in-memory GeMM macro: ROWS x COLS signed weights, ROWS inputs, COLS accumulators.
// Row-sequential MVM over ROWS cycles; reads are held in RESP until the response handshake.
module param_gemm_cim #(
  parameter int ROWS  = 16,
  parameter int COLS  = 4,
  parameter int WBITS = 8,
  parameter int IBITS = 8,
  parameter int ACC_W = 32,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             cs,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_addr,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_psum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_data,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = WBITS + IBITS;

  localparam logic [2:0] OP_WR_W    = 3'd1;
  localparam logic [2:0] OP_WR_IN   = 3'd2;
  localparam logic [2:0] OP_COMPUTE = 3'd3;
  localparam logic [2:0] OP_RD_OUT  = 3'd4;
  localparam logic [2:0] OP_CLR     = 3'd5;
  localparam logic [2:0] OP_RD_W    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_t;
  state_t state_q, state_d;

  logic [WBITS-1:0] w_q   [ROWS][COLS];
  logic [IBITS-1:0] in_q  [ROWS];
  logic [ACC_W-1:0] acc_q [COLS];
  logic [ACC_W-1:0] acc_d [COLS];
  logic [ACC_W-1:0] base  [COLS];
  logic [PW-1:0]    prod  [COLS];
  logic [ACC_W:0]   sum   [COLS];
  logic [RW-1:0]    row_q;
  logic             psum_q, done_q, err_q;
  logic [ACC_W-1:0] rsp_data_q, rd_val;
  logic [31:0]      wrow_pack;
  logic             accept, row_ok, last_row;
  logic [RW-1:0]    addr_row;
  logic [CW-1:0]    addr_col;
  logic             unused_data;

  assign accept      = cmd_valid & cmd_ready;
  assign row_ok      = {24'd0, cmd_addr} < ROWS;
  assign addr_row    = cmd_addr[RW-1:0];
  assign addr_col    = cmd_addr[CW-1:0];
  assign last_row    = (row_q == RW'(ROWS - 1));
  assign unused_data = ^cmd_data;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_op == OP_COMPUTE)                          state_d = S_COMPUTE;
        else if (accept && (cmd_op == OP_RD_OUT || cmd_op == OP_RD_W)) state_d = S_RESP;
      end
      S_COMPUTE: if (last_row)  state_d = S_IDLE;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = cs & (state_q == S_IDLE);
    busy      = (state_q == S_COMPUTE);
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_data_q;
    done      = done_q;
    err       = err_q;
  end

  always_comb begin
    wrow_pack = '0;
    for (int c = 0; c < COLS; c++) wrow_pack[c*WBITS +: WBITS] = w_q[addr_row][c];
    rd_val = '0;
    if (cmd_op == OP_RD_OUT) begin
      if ({24'd0, cmd_addr} < COLS) rd_val = acc_q[addr_col];
    end else if (row_ok) begin
      rd_val = wrow_pack[ACC_W-1:0];
    end
  end

  // Row 0 without psum starts from zero, so a fresh compute needs no separate clear cycle.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      base[c] = (row_q == '0 && !psum_q) ? '0 : acc_q[c];
      prod[c] = PW'($signed(PW'($signed(w_q[row_q][c])) * PW'($signed(in_q[row_q]))));
      sum[c]  = {base[c][ACC_W-1], base[c]} + {{(ACC_W+1-PW){prod[c][PW-1]}}, prod[c]};
      if (SAT != 0 && sum[c][ACC_W] != sum[c][ACC_W-1])
        acc_d[c] = sum[c][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_d[c] = sum[c][ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int r = 0; r < ROWS; r++) begin
        in_q[r] <= '0;
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
      end
      for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
      row_q      <= '0;
      psum_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      done_q <= (state_q == S_COMPUTE) && last_row;
      if (state_q == S_COMPUTE) begin
        for (int c = 0; c < COLS; c++) acc_q[c] <= acc_d[c];
        row_q <= row_q + RW'(1);
      end
      if (accept) begin
        case (cmd_op)
          OP_WR_W:    if (row_ok) for (int c = 0; c < COLS; c++) w_q[addr_row][c] <= cmd_data[c*WBITS +: WBITS];
          OP_WR_IN:   if (row_ok) in_q[addr_row] <= cmd_data[IBITS-1:0];
          OP_COMPUTE: begin
            row_q  <= '0;
            psum_q <= cmd_psum;
          end
          OP_RD_OUT, OP_RD_W: rsp_data_q <= rd_val;
          OP_CLR:     for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
          OP_ILLEGAL: err_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_param_gemm_cim.sv
// Bench for param_gemm_cim: three instances (ACC_W=32 sat, ACC_W=16 sat, ACC_W=16 wrap) share one command stream.
module tb_param_gemm_cim;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n, cs, cmd_valid, cmd_psum, rsp_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;

  logic        cmd_ready_a, rsp_valid_a, busy_a, done_a, err_a;
  logic        cmd_ready_b, rsp_valid_b, busy_b, done_b, err_b;
  logic        cmd_ready_c, rsp_valid_c, busy_c, done_c, err_c;
  logic [31:0] rsp_data_a;
  logic [15:0] rsp_data_b, rsp_data_c;

  param_gemm_cim #(.ROWS(16), .COLS(4), .WBITS(8), .IBITS(8), .ACC_W(32), .SAT(1)) dut_a (
    .clk(clk), .res_n(res_n), .cs(cs), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_psum(cmd_psum),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
    .busy(busy_a), .done(done_a), .err(err_a));
  param_gemm_cim #(.ROWS(16), .COLS(4), .WBITS(8), .IBITS(8), .ACC_W(16), .SAT(1)) dut_b (
    .clk(clk), .res_n(res_n), .cs(cs), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_psum(cmd_psum),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
    .busy(busy_b), .done(done_b), .err(err_b));
  param_gemm_cim #(.ROWS(16), .COLS(4), .WBITS(8), .IBITS(8), .ACC_W(16), .SAT(0)) dut_c (
    .clk(clk), .res_n(res_n), .cs(cs), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_c),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_psum(cmd_psum),
    .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready), .rsp_data(rsp_data_c),
    .busy(busy_c), .done(done_c), .err(err_c));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer matrix-vector arithmetic per configuration.
  longint mw   [16][4];
  longint min_ [16];
  longint macc [3][4];
  int     accw_cfg [3] = '{32, 16, 16};
  bit     sat_cfg  [3] = '{1'b1, 1'b1, 1'b0};
  longint exp_tp1  [4] = '{120, 240, -360, 480};

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint fold(input longint v, input int bits, input bit s);
    longint m, hi, lo, r;
    m  = longint'(1) << bits;
    hi = m / 2 - 1;
    lo = -(m / 2);
    if (s) return (v > hi) ? hi : ((v < lo) ? lo : v);
    r = v % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
    return r;
  endfunction

  function automatic logic [31:0] model_row(input int r);
    logic [31:0] pk;
    longint v;
    pk = '0;
    if (r < 16)
      for (int c = 0; c < 4; c++) begin
        v = mw[r][c];
        pk[c*8 +: 8] = v[7:0];
      end
    return pk;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      min_[r] = 0;
      for (int c = 0; c < 4; c++) mw[r][c] = 0;
    end
    for (int i = 0; i < 3; i++) for (int c = 0; c < 4; c++) macc[i][c] = 0;
  endtask

  task automatic model_compute(input logic psum);
    for (int i = 0; i < 3; i++) begin
      if (!psum) for (int c = 0; c < 4; c++) macc[i][c] = 0;
      for (int k = 0; k < 16; k++)
        for (int c = 0; c < 4; c++)
          macc[i][c] = fold(macc[i][c] + mw[k][c] * min_[k], accw_cfg[i], sat_cfg[i]);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] data, input logic psum);
    int n;
    n = 0;
    @(negedge clk);
    cs = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_psum = psum; cmd_valid = 1'b1;
    #1;
    while (cmd_ready_a !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", cmd_ready_a, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic wr_w(input int r, input logic [31:0] d);
    byte b;
    issue(3'd1, 8'(r), d, 1'b0);
    if (r < 16) for (int c = 0; c < 4; c++) begin
      b = d[c*8 +: 8];
      mw[r][c] = b;
    end
  endtask

  task automatic wr_in(input int r, input logic [31:0] d);
    byte b;
    issue(3'd2, 8'(r), d, 1'b0);
    b = d[7:0];
    if (r < 16) min_[r] = b;
  endtask

  task automatic clr();
    issue(3'd5, 8'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) for (int c = 0; c < 4; c++) macc[i][c] = 0;
  endtask

  task automatic compute(input logic psum, input logic drop_cs);
    int nb, nd;
    nb = 0; nd = 0;
    issue(3'd3, 8'd0, 32'd0, psum);
    model_compute(psum);
    if (drop_cs) cs = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) nb++;
      if (done_a === 1'b1) nd++;
    end
    cs = 1'b1;
    check("busy_cycles", nb, 16);
    check("done_pulses", nd, 1);
  endtask

  task automatic rd(input logic [2:0] op, input int addr,
                    output logic signed [63:0] da, output logic signed [63:0] db, output logic signed [63:0] dc);
    int n;
    n = 0;
    issue(op, 8'(addr), 32'd0, 1'b0);
    while (rsp_valid_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rsp_timeout", rsp_valid_a, 1);
    da = $signed(rsp_data_a);
    db = $signed(rsp_data_b);
    dc = $signed(rsp_data_c);
    @(posedge clk); #1;
  endtask

  initial begin
    logic signed [63:0] da, db, dc;
    logic [31:0] pk;
    int rr;

    res_n = 1'b0; cs = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 8'd0;
    cmd_data = 32'd0; cmd_psum = 1'b0; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rsp_data", rsp_data_a, 0);
    check("rst_cmd_ready", cmd_ready_a, 1);
    res_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      wr_w(r, 32'h04FD0201);
      wr_in(r, 32'(r));
    end
    compute(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      rd(3'd4, c, da, db, dc);
      check($sformatf("tp1_acc%0d", c), da, exp_tp1[c]);
    end

    compute(1'b1, 1'b1);
    rd(3'd4, 0, da, db, dc); check("psum_acc0", da, 240);
    rd(3'd4, 3, da, db, dc); check("psum_acc3", da, 960);
    clr();
    rd(3'd4, 3, da, db, dc); check("clr_acc3", da, 0);
    rd(3'd6, 5, da, db, dc); check("rdw_row5", da, $signed(32'h04FD0201));
    rd(3'd6, 20, da, db, dc); check("rdw_oob", da, 0);
    check("err_clean", err_a, 0);

    for (int r = 0; r < 16; r++) begin
      wr_w(r, 32'h81817F7F);
      wr_in(r, 32'd127);
    end
    compute(1'b0, 1'b0);
    rd(3'd4, 0, da, db, dc);
    check("sat_pos_w32", da, 258064);
    check("sat_pos_w16", db, 32767);
    check("wrap_pos_w16", dc, -4080);
    rd(3'd4, 2, da, db, dc);
    check("sat_neg_w32", da, -258064);
    check("sat_neg_w16", db, -32768);
    check("wrap_neg_w16", dc, 4080);

    rsp_ready = 1'b0;
    issue(3'd4, 8'd1, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid_a, 1);
      check("hold_rsp_data", $signed(rsp_data_a), 258064);
      check("hold_cmd_ready", cmd_ready_a, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_rsp_valid", rsp_valid_a, 0);
    check("post_hs_cmd_ready", cmd_ready_a, 1);
    rd(3'd4, 9, da, db, dc); check("rdout_oob", da, 0);

    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 16; r++) begin
        wr_w(r, $urandom);
        wr_in(r, $urandom);
      end
      compute((it == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
      for (int c = 0; c < 4; c++) begin
        rd(3'd4, c, da, db, dc);
        check($sformatf("rnd%0d_w32_acc%0d", it, c), da, macc[0][c]);
        check($sformatf("rnd%0d_sat16_acc%0d", it, c), db, macc[1][c]);
        check($sformatf("rnd%0d_wrap16_acc%0d", it, c), dc, macc[2][c]);
      end
      rr = $urandom_range(0, 15);
      pk = model_row(rr);
      rd(3'd6, rr, da, db, dc);
      check($sformatf("rnd%0d_rdw", it), da, $signed(pk));
    end

    issue(3'd3, 8'd0, 32'd0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_done_in_rst", done_a, 0);
    end
    res_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_done_after", done_a, 0);
      check("abort_busy_after", busy_a, 0);
    end
    rd(3'd4, 0, da, db, dc); check("abort_acc0", da, 0);
    rd(3'd6, 3, da, db, dc); check("abort_w3", da, 0);

    issue(3'd7, 8'd0, 32'd0, 1'b0);
    check("illegal_err", err_a, 1);
    issue(3'd0, 8'd0, 32'd0, 1'b0);
    wr_in(0, 32'd5);
    rd(3'd4, 1, da, db, dc); check("illegal_noeffect", da, 0);
    check("err_sticky", err_a, 1);

    @(negedge clk);
    cs = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = 8'd0; cmd_data = 32'h01010101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cs0_cmd_ready", cmd_ready_a, 0);
      check("cs0_busy", busy_a, 0);
    end
    cmd_op = 3'd1;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rd(3'd6, 0, da, db, dc); check("cs0_no_write", da, 0);
    check("err_sticky_end", err_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/param_gemm_cim.md
Name: param_gemm_cim

Overview:
- Parametrised second-generation compute-in-memory GeMM macro for the RISC-V PIM system; successor to the basic single-configuration CIM unit.
- Holds a ROWS x COLS signed weight array, a ROWS-entry input buffer and COLS accumulators.
- Driven by a valid/ready command port from the CPU-side CIM interface. Computes a row-sequential matrix-vector product with optional partial-sum accumulation and optional saturation; results are returned through a valid/ready response port.

Parameters:
- ROWS, 16: weight rows, equal to input vector length; must be 2..256.
- COLS, 4: output channels / accumulators; COLS*WBITS <= 32.
- WBITS, 8: signed weight width.
- IBITS, 8: signed input element width.
- ACC_W, 32: signed accumulator and response width, 16..32.
- SAT, 1: 1 = saturating accumulate, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge
- res_n  in  1  reset; the block uses one clock, and reset is asynchronous and active-low
- cs  in  1  chip select
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready; equals cs & (state==IDLE)
- cmd_op  in  3  opcode
- cmd_addr  in  8  row or column index
- cmd_data  in  32  write data
- cmd_psum  in  1  COMPUTE only: 1 = add to existing accumulators
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  ACC_W  response data
- busy  out  1  high during COMPUTE
- done  out  1  one-cycle pulse, compute finished
- err  out  1  sticky illegal-command flag

Behaviour:
- Reset (async, res_n=0): state=IDLE; weights, inputs and accumulators cleared to 0; rsp_valid=0, rsp_data=0, busy=0, done=0, err=0. Reset mid-COMPUTE or mid-RESP aborts the operation immediately.
- A command is accepted on a rising edge with cmd_valid & cmd_ready. Commands are never accepted while cs=0. Deasserting cs does not stop a COMPUTE or RESP already in progress.
- Opcodes:
  - 0 NOP: no effect.
  - 1 WR_W: row=cmd_addr. Weight w[row][c] = cmd_data[c*WBITS +: WBITS] for every c.
  - 2 WR_IN: in[cmd_addr] = cmd_data[IBITS-1:0].
  - 3 COMPUTE: see below.
  - 4 RD_OUT: rsp_data = acc[cmd_addr]; returns 0 if cmd_addr >= COLS.
  - 5 CLR: all acc = 0.
  - 6 RD_W: rsp_data = zero-extended packed weight row cmd_addr.
  - 7 illegal: err set to 1 and held until reset; no other effect.
- Any cmd_addr >= ROWS on opcodes 1, 2 or 6 is ignored for writes and returns 0 for reads; err is not set.
- States IDLE, COMPUTE, RESP.
  - IDLE->COMPUTE on accepting opcode 3. If cmd_psum=0, the accumulators are treated as 0 for the row-0 update (clear-and-add in one cycle).
  - COMPUTE: busy=1 for exactly ROWS cycles. Cycle k (k=0..ROWS-1) performs acc[c] = f(acc[c] + sext(w[k][c]*in[k])) for all c in parallel.
    - The product is signed, WBITS+IBITS bits wide, sign-extended to ACC_W.
    - f clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] when SAT=1 and wraps when SAT=0.
  - COMPUTE->IDLE after row ROWS-1. done=1 for the single first IDLE cycle.
  - IDLE->RESP on accepting opcode 4 or 6. rsp_valid rises the next cycle and rsp_data is registered. Both are held stable until rsp_valid & rsp_ready, after which the block returns to IDLE and rsp_valid=0. rsp_data keeps its last value.
- Writes to weights or inputs are impossible during COMPUTE because cmd_ready=0.
- No back-to-back acceptance from RESP; the next command is accepted earliest in the cycle after the handshake.

Test Plan:
- Set every row to {c3=4, c2=-3, c1=2, c0=1} (cmd_data=0x04FD0201) and in[r]=r for r=0..15. Issue COMPUTE with psum=0, then RD_OUT 0..3 -> 120, 240, -360, 480. busy is high exactly 16 cycles and done pulses once.
- Repeat COMPUTE with psum=1, then RD_OUT 0 -> 240 and RD_OUT 3 -> 960. Then CLR and RD_OUT 3 -> 0.
- With ACC_W=16, all weights 127, all inputs 127, COMPUTE: SAT=1 -> acc0 = 32767; SAT=0 -> acc0 = -4080 (258064 mod 2^16).
- Hold rsp_ready=0 for 5 cycles after RD_OUT 1 -> rsp_valid=1 with stable data and cmd_ready=0 throughout. Assert rsp_ready -> one handshake, then cmd_ready=1 the next cycle. RD_OUT 9 -> 0.
- Assert res_n=0 during COMPUTE row 7 -> busy=0 immediately, no done pulse, and RD_OUT 0 after reset -> 0.
- Issue opcode 7 -> err=1, persisting across later valid commands. With cs=0 and cmd_valid=1, cmd_ready=0 and no state change occurs.
